// File: rtl/if_id_queue.sv
// if_id_queue: circular FIFO between instruction fetch (IF) and decode (ID), with a flush on branch mispredict.
// Latency: an entry pushed on edge N shows on id_* after edge N. With IF_ID_QUEUE_BYPASS_EN it can pass straight through.
// Backpressure: if_ready is low while full, even when a pop happens in the same cycle. rdy low freezes all state.
//
// Ports:
//   clk, rst_n (async active-low), rdy (global enable)
//   if_valid/if_pc/if_inst -> if_ready            : fetch side
//   ex_is_branch/ex_branch_pc                     : resolved control transfer from EX
//   id_valid/id_pc/id_inst, id_ready              : decode side (head entry)
//   count                                         : occupied entries
//   flush_o                                       : flush taken this cycle (combinational)
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN. When it is defined, an empty queue
// forwards the IF offer straight to ID in the same cycle.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    input  logic                     ex_is_branch,
    input  logic [ADDR_W-1:0]        ex_branch_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     flush_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              q_valid;
    logic [ADDR_W-1:0] q_pc;
    logic [INST_W-1:0] q_inst;
    logic              byp_take;
    logic              push;
    logic              pop;

    // Head of the stored queue. The outputs are forced to zero when the queue is empty,
    // so the storage array needs no reset.
    assign q_valid = (count_q != '0);
    assign q_pc    = q_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign q_inst  = q_valid ? inst_mem_q[rd_ptr_q] : '0;

    // Flush is judged against the stored head only. With bypass enabled, basing it on
    // id_* would create a combinational loop through the bypass mux. An empty queue
    // therefore always treats a resolved branch as a redirect.
    assign flush_o  = ex_is_branch && (!q_valid || (ex_branch_pc != q_pc));
    assign if_ready = (count_q != CNT_W'(DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic byp_act;
    assign byp_act  = (count_q == '0) && !flush_o;
    // A bypassed entry that ID consumes in this same cycle is never written to storage.
    assign byp_take = byp_act && rdy && if_valid && id_ready;
    assign id_valid = byp_act ? if_valid : q_valid;
    assign id_pc    = byp_act ? if_pc    : q_pc;
    assign id_inst  = byp_act ? if_inst  : q_inst;
`else
    assign byp_take = 1'b0;
    assign id_valid = q_valid;
    assign id_pc    = q_pc;
    assign id_inst  = q_inst;
`endif

    assign push  = rdy && if_valid && if_ready && !flush_o && !byp_take;
    assign pop   = rdy && q_valid && id_ready && !flush_o;
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rdy && flush_o) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            inst_mem_q[wr_ptr_q] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        ex_is_branch;
    logic [31:0] ex_branch_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;
    logic        flush_o;

    int vectors    = 0;
    int miscompares = 0;

    if_id_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_ready     (if_ready),
        .ex_is_branch (ex_is_branch),
        .ex_branch_pc (ex_branch_pc),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .count        (count),
        .flush_o      (flush_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Advance one edge. Inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        ex_is_branch = 1'b0; ex_branch_pc = '0; id_ready = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc);
        if_valid = 1'b1; if_pc = pc; if_inst = inst_of(pc); id_ready = 1'b0;
        cyc();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
        vectors++; if (id_pc !== 32'h0)   begin miscompares++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
        vectors++; if (id_inst !== 32'h0) begin miscompares++; $display("FAIL reset_id_inst got %h exp 0", id_inst); end
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready got %b exp 1", if_ready); end
        cyc();
        rst_n = 1'b1;
        cyc();
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL post_reset_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc;
        idle();
        for (int i = 0; i < 4; i++) begin
            push_one(32'(i * 4));
            vectors++; if (count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
        end
        vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL fill_if_ready got %b exp 0", if_ready); end
        vectors++; if (id_pc !== 32'h0)   begin miscompares++; $display("FAIL fill_head_pc got %h exp 0", id_pc); end
        vectors++; if (id_inst !== inst_of(32'h0)) begin miscompares++; $display("FAIL fill_head_inst got %h exp %h", id_inst, inst_of(32'h0)); end
        // A fifth push while full is ignored.
        push_one(32'h10);
        vectors++; if (count !== 3'd4)    begin miscompares++; $display("FAIL fifth_push_count got %0d exp 4", count); end
        // When full, a simultaneous push and pop must not push through: only the pop happens.
        if_valid = 1'b1; if_pc = 32'h14; if_inst = inst_of(32'h14); id_ready = 1'b1;
        cyc();
        idle();
        vectors++; if (count !== 3'd3)    begin miscompares++; $display("FAIL full_pushpop_count got %0d exp 3", count); end
        // Drain the rest. 0x14 must not appear.
        for (int i = 1; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            vectors++; if (id_pc !== exp_pc) begin miscompares++; $display("FAIL drain_pc[%0d] got %h exp %h", i, id_pc, exp_pc); end
            id_ready = 1'b1;
            cyc();
            id_ready = 1'b0;
        end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty_valid got %b exp 0", id_valid); end
        vectors++; if (id_pc !== 32'h0)   begin miscompares++; $display("FAIL drain_empty_pc got %h exp 0", id_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        idle();
        push_one(32'h20);
        push_one(32'h24);
        for (int k = 0; k < 6; k++) begin
            if_valid = 1'b1; if_pc = 32'(32'h28 + 4 * k); if_inst = inst_of(if_pc); id_ready = 1'b1;
            #1;
            exp_pc = 32'(32'h20 + 4 * k);
            vectors++; if (id_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, id_pc, exp_pc); end
            cyc();
            vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d exp 2", k, count); end
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            exp_pc = 32'(32'h38 + 4 * k);
            vectors++; if (id_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_tail_pc[%0d] got %h exp %h", k, id_pc, exp_pc); end
            vectors++; if (id_inst !== inst_of(exp_pc)) begin miscompares++; $display("FAIL wrap_tail_inst[%0d] got %h exp %h", k, id_inst, inst_of(exp_pc)); end
            id_ready = 1'b1;
            cyc();
            id_ready = 1'b0;
        end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL wrap_final_count got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        idle();
        push_one(32'h10);
        push_one(32'h14);
        ex_is_branch = 1'b1; ex_branch_pc = 32'h40;
        if_valid = 1'b1; if_pc = 32'h40; if_inst = inst_of(32'h40); id_ready = 1'b1;
        #1;
        vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL flush_o got %b exp 1", flush_o); end
        cyc();
        idle();
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL flush_count got %0d exp 0", count); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush_id_valid got %b exp 0", id_valid); end
        cyc();
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL flush_not_stored got %0d exp 0", count); end
        // A branch resolved while the queue is empty is a redirect.
        ex_is_branch = 1'b1; ex_branch_pc = 32'h0;
        #1;
        vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL flush_empty got %b exp 1", flush_o); end
        idle();
    endtask

    task automatic test_correct_pred();
        idle();
        push_one(32'h10);
        push_one(32'h14);
        ex_is_branch = 1'b1; ex_branch_pc = 32'h10; id_ready = 1'b1;
        #1;
        vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL pred_flush got %b exp 0", flush_o); end
        cyc();
        idle();
        vectors++; if (count !== 3'd1)   begin miscompares++; $display("FAIL pred_count got %0d exp 1", count); end
        vectors++; if (id_pc !== 32'h14) begin miscompares++; $display("FAIL pred_head got %h exp 14", id_pc); end
        id_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_stall();
        idle();
        push_one(32'h50);
        rdy = 1'b0; if_valid = 1'b1; if_pc = 32'h54; if_inst = inst_of(32'h54); id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++; if (count !== 3'd1)   begin miscompares++; $display("FAIL stall_count[%0d] got %0d exp 1", i, count); end
            vectors++; if (id_pc !== 32'h50) begin miscompares++; $display("FAIL stall_pc[%0d] got %h exp 50", i, id_pc); end
        end
        idle();
        id_ready = 1'b1;
        cyc();
        idle();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL stall_release_count got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        idle();
        push_one(32'h60);
        push_one(32'h64);
        rst_n = 1'b0;
        #1;
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL midreset_count got %0d exp 0", count); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b exp 0", id_valid); end
        cyc();
        rst_n = 1'b1;
        #1;
        push_one(32'h70);
        vectors++; if (count !== 3'd1)   begin miscompares++; $display("FAIL resume_count got %0d exp 1", count); end
        vectors++; if (id_pc !== 32'h70) begin miscompares++; $display("FAIL resume_pc got %h exp 70", id_pc); end
        id_ready = 1'b1;
        cyc();
        idle();
    endtask

`ifdef IF_ID_QUEUE_BYPASS_EN
    task automatic test_bypass();
        idle();
        if_valid = 1'b1; if_pc = 32'h80; if_inst = inst_of(32'h80); id_ready = 1'b1;
        #1;
        vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL byp_valid got %b exp 1", id_valid); end
        vectors++; if (id_pc !== 32'h80)  begin miscompares++; $display("FAIL byp_pc got %h exp 80", id_pc); end
        cyc();
        vectors++; if (count !== 3'd0)    begin miscompares++; $display("FAIL byp_count got %0d exp 0", count); end
        id_ready = 1'b0;
        cyc();
        vectors++; if (count !== 3'd1)    begin miscompares++; $display("FAIL byp_store_count got %0d exp 1", count); end
        idle();
        id_ready = 1'b1;
        cyc();
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_correct_pred();
        test_stall();
        test_reset_mid();
`ifdef IF_ID_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
